uart_tx: RTL and testbench

Serial transmitter for the UART link, the transmit-side counterpart of the oversampled receive path. It accepts one parallel word through a valid/busy handshake and serializes it as start bit, LSB-first data, optional parity, and stop bit on `TX_OUT`. Each bit is held for `Prescale` cycles of `CLK`, the same oversampling clock and ratio the receiver uses, so one prescale setting drives both ends.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_bit_timer.sv | 42 ++++
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels, parity encoding
// and the prescale clamp used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic       UART_START_BIT    = 1'b0;
  localparam logic       UART_STOP_BIT     = 1'b1;
  localparam logic [4:0] UART_PRESCALE_MIN = 5'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Settings below the minimum oversampling ratio are raised to it.
  function automatic logic [4:0] clamp_prescale(input logic [4:0] prescale);
    return (prescale < UART_PRESCALE_MIN) ? UART_PRESCALE_MIN : prescale;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: latches the clamped prescale at frame accept and pulses
// bit_done_o on the last cycle of every bit while a frame is running.
module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [4:0] prescale_i,
  input  logic       run_i,
  output logic       bit_done_o
);

  logic [4:0] prescale_q, prescale_d;
  logic [4:0] cnt_q, cnt_d;

  assign bit_done_o = run_i && (cnt_q == (prescale_q - 5'd1));

  // State changes only happen on bit_done or out of IDLE, so wrapping at the
  // terminal count and holding zero while idle clears on every transition.
  always_comb begin
    prescale_d = prescale_q;
    cnt_d      = cnt_q + 5'd1;
    if (load_i) begin
      prescale_d = clamp_prescale(prescale_i);
    end
    if (!run_i || bit_done_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prescale_q <= UART_PRESCALE_MIN;
      cnt_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit,
// each held for the latched prescale; valid/busy handshake, registered outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [4:0]            Prescale,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_tx_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  bit_done;

  assign accept = (state_q == IDLE) && Data_Valid;

  uart_tx_bit_timer u_bit_timer (
    .clk_i      (CLK),
    .rst_ni     (Reset),
    .load_i     (accept),
    .prescale_i (Prescale),
    .run_i      (state_q != IDLE),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = UART_STOP_BIT;
    busy_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          data_d    = P_Data;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_Data) ^ (PAR_TYP == PAR_ODD);
          idx_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the line changes on the
    // same edge the FSM moves, with no input-to-output combinational path.
    unique case (state_d)
      START:   tx_d = UART_START_BIT;
      DATA:    tx_d = data_d[idx_d];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = UART_STOP_BIT;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= UART_STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed vector table, corner-case
// sequences and random frames against a bit-list reference model.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [4:0] Prescale;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic obs_q[$];
  logic exp_q[$];

  typedef struct {
    logic [4:0] ps;
    logic [7:0] d;
    logic       pe;
    logic       pt;
    bit         mid;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t tbl[6];

  always #5 CLK = ~CLK;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Prescale   (Prescale),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int eff_of(input logic [4:0] ps);
    return (ps < 5) ? 5 : int'(ps);
  endfunction

  // Reference: list of line levels for the frame, each repeated eff times.
  task automatic build_model(input logic [4:0] ps, input logic [7:0] d,
                             input logic pe, input logic pt);
    logic bits[$];
    int   eff;
    eff = eff_of(ps);
    exp_q.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
    foreach (bits[b]) repeat (eff) exp_q.push_back(bits[b]);
  endtask

  // Called #1 after an edge in IDLE; returns at the first cycle of the frame
  // with inputs scrambled so that only latched values can matter.
  task automatic accept(input logic [4:0] ps, input logic [7:0] d,
                        input logic pe, input logic pt);
    Prescale   = ps;
    P_Data     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    P_Data     = ~d;
    PAR_EN     = ~pe;
    PAR_TYP    = ~pt;
    Prescale   = 5'($urandom_range(0, 31));
  endtask

  task automatic capture(input string name, input int mid_at, output int blen);
    obs_q.delete();
    blen = 0;
    while (Busy === 1'b1 && blen < 1100) begin
      obs_q.push_back(TX_OUT);
      if (mid_at >= 0 && blen == mid_at) begin
        Data_Valid = 1'b1;
        P_Data     = 8'h00;
        PAR_EN     = ~PAR_EN;
        Prescale   = 5'd31;
      end else if (mid_at >= 0 && blen == mid_at + 1) begin
        Data_Valid = 1'b0;
      end
      step();
      blen++;
    end
    check({name, " busy_bounded"}, 32'(blen < 1100), 32'd1);
  endtask

  task automatic compare_wave(input string name);
    int n, mism, first;
    n     = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    mism  = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL %s wave: %0d cycles differ (first at %0d, got %0d cycles, expected %0d), required 0",
               name, mism, first, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic idle_check(input string name);
    int bad;
    bad = 0;
    repeat (8) begin
      if (Busy !== 1'b0 || TX_OUT !== 1'b1) bad++;
      step();
    end
    check({name, " idle_after"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int   blen, eff, pidx;
    logic [4:0] rps;
    logic [7:0] rd;
    logic       rpe, rpt;

    tbl[0] = '{5'd8,  8'hA5, 1'b1, 1'b0, 1'b0, 88,  1'b0};
    tbl[1] = '{5'd16, 8'h01, 1'b1, 1'b1, 1'b0, 176, 1'b0};
    tbl[2] = '{5'd16, 8'h03, 1'b1, 1'b1, 1'b0, 176, 1'b1};
    tbl[3] = '{5'd3,  8'hFF, 1'b0, 1'b0, 1'b0, 50,  1'b0};
    tbl[4] = '{5'd31, 8'h5A, 1'b0, 1'b1, 1'b0, 310, 1'b0};
    tbl[5] = '{5'd8,  8'hC3, 1'b1, 1'b0, 1'b1, 88,  1'b0};

    Reset      = 1'b0;
    Data_Valid = 1'b0;
    Prescale   = 5'd8;
    P_Data     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (3) step();
    check("reset TX_OUT", 32'(TX_OUT), 32'd1);
    check("reset Busy", 32'(Busy), 32'd0);
    Reset = 1'b1;
    step();
    check("post-reset TX_OUT", 32'(TX_OUT), 32'd1);
    check("post-reset Busy", 32'(Busy), 32'd0);

    foreach (tbl[i]) begin
      string nm;
      nm  = $sformatf("vec%0d", i);
      eff = eff_of(tbl[i].ps);
      accept(tbl[i].ps, tbl[i].d, tbl[i].pe, tbl[i].pt);
      capture(nm, tbl[i].mid ? 3 * eff : -1, blen);
      build_model(tbl[i].ps, tbl[i].d, tbl[i].pe, tbl[i].pt);
      compare_wave(nm);
      check({nm, " busy_len"}, 32'(blen), 32'(tbl[i].exp_len));
      if (tbl[i].pe) begin
        pidx = 9 * eff + eff / 2;
        check({nm, " parity"}, (pidx < obs_q.size()) ? 32'(obs_q[pidx]) : 32'hFFFF_FFFF,
              32'(tbl[i].exp_par));
      end
      idle_check(nm);
    end

    // Data_Valid held high: one idle cycle between frames, second payload
    // taken from P_Data at its own accept.
    Prescale   = 5'd5;
    P_Data     = 8'hFF;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    step();
    P_Data = 8'h3C;
    capture("b2b1", -1, blen);
    build_model(5'd5, 8'hFF, 1'b0, 1'b0);
    compare_wave("b2b1");
    check("b2b1 busy_len", 32'(blen), 32'd50);
    check("b2b gap", {30'd0, TX_OUT, Busy}, 32'b10);
    step();
    Data_Valid = 1'b0;
    P_Data     = 8'h99;
    capture("b2b2", -1, blen);
    build_model(5'd5, 8'h3C, 1'b0, 1'b0);
    compare_wave("b2b2");
    check("b2b2 busy_len", 32'(blen), 32'd50);
    idle_check("b2b2");

    // Reset during the parity bit abandons the frame on the next edge.
    accept(5'd8, 8'hA5, 1'b1, 1'b0);
    repeat (75) step();
    check("pre-reset parity TX_OUT", 32'(TX_OUT), 32'd0);
    check("pre-reset Busy", 32'(Busy), 32'd1);
    Reset = 1'b0;
    step();
    check("midreset TX_OUT", 32'(TX_OUT), 32'd1);
    check("midreset Busy", 32'(Busy), 32'd0);
    Reset = 1'b1;
    step();
    accept(5'd8, 8'h5A, 1'b1, 1'b1);
    check("restart first TX_OUT", 32'(TX_OUT), 32'd0);
    capture("restart", -1, blen);
    build_model(5'd8, 8'h5A, 1'b1, 1'b1);
    compare_wave("restart");
    check("restart busy_len", 32'(blen), 32'd88);
    idle_check("restart");

    for (int k = 0; k < 10; k++) begin
      string nm;
      nm  = $sformatf("rand%0d", k);
      rps = 5'($urandom_range(0, 31));
      rd  = 8'($urandom);
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      eff = eff_of(rps);
      accept(rps, rd, rpe, rpt);
      capture(nm, -1, blen);
      build_model(rps, rd, rpe, rpt);
      compare_wave(nm);
      check({nm, " busy_len"}, 32'(blen), 32'((rpe ? 11 : 10) * eff));
      idle_check(nm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
